// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen
// Description : Program-counter generator feeding the instruction memory.
//               Optional fetch counter enabled by macro PC_GEN_FETCH_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen #(
    parameter int                  ADDR_LEN = 8,
    parameter logic [ADDR_LEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                PCsrc,
    input  logic [ADDR_LEN-1:0] ImmOp,
    input  logic                jalr_en,
    input  logic [ADDR_LEN-1:0] jalr_target,
    output logic [ADDR_LEN-1:0] PC,
    output logic [ADDR_LEN-1:0] PC_plus4,
    output logic                fetch_valid,
`ifdef PC_GEN_FETCH_CNT_EN
    output logic                misalign,
    output logic [31:0]         fetch_count
`else
    output logic                misalign
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_LEN-1:0] pc_next;
    logic [ADDR_LEN-1:0] target;
    logic                misalign_next;
    logic                step;

    assign PC_plus4    = PC + ADDR_LEN'(4);
    assign fetch_valid = (state == RUN);
    assign step        = (state == RUN) && en;

    // Redirect priority: jalr over PC-relative over sequential.
    always_comb begin
        target = PC_plus4;
        if (jalr_en) begin
            target = {jalr_target[ADDR_LEN-1:1], 1'b0};
        end else if (PCsrc) begin
            target = PC + ImmOp;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = PC;
        misalign_next = misalign;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (en) begin
                    if (target[1:0] != 2'b00) begin
                        state_next    = HALT;
                        misalign_next = 1'b1;
                    end else begin
                        pc_next = target;
                    end
                end
            end
            HALT: state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            PC       <= RESET_PC;
            misalign <= 1'b0;
        end else begin
            state    <= state_next;
            PC       <= pc_next;
            misalign <= misalign_next;
        end
    end

`ifdef PC_GEN_FETCH_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (step && (fetch_count != 32'hFFFF_FFFF)) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`else
    logic unused_step;
    assign unused_step = step;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// Directed self-checking bench for pc_gen (ADDR_LEN=8, RESET_PC=0).
module tb_pc_gen;

    logic       clk = 1'b0;
    logic       rst, en, PCsrc, jalr_en;
    logic [7:0] ImmOp, jalr_target;
    logic [7:0] PC, PC_plus4;
    logic       fetch_valid, misalign;
`ifdef PC_GEN_FETCH_CNT_EN
    logic [31:0] fetch_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_gen #(.ADDR_LEN(8), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .PCsrc      (PCsrc),
        .ImmOp      (ImmOp),
        .jalr_en    (jalr_en),
        .jalr_target(jalr_target),
        .PC         (PC),
        .PC_plus4   (PC_plus4),
        .fetch_valid(fetch_valid),
`ifdef PC_GEN_FETCH_CNT_EN
        .misalign   (misalign),
        .fetch_count(fetch_count)
`else
        .misalign   (misalign)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        en = 1'b0; PCsrc = 1'b0; jalr_en = 1'b0;
        ImmOp = 8'h00; jalr_target = 8'h00;
    endtask

    // Reset for two cycles, release, then pass the boot cycle.
    task automatic reset_and_boot();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        en  = 1'b1;
        tick();
    endtask

    task automatic goto_pc(input logic [7:0] addr);
        en = 1'b1; jalr_en = 1'b1; jalr_target = addr;
        tick();
        jalr_en = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        checks++; if (PC !== 8'h00) begin errors++; $display("FAIL reset_pc got=%h exp=00", PC); end
        checks++; if (PC_plus4 !== 8'h04) begin errors++; $display("FAIL reset_pc4 got=%h exp=04", PC_plus4); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", fetch_valid); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_mis got=%b exp=0", misalign); end
        rst = 1'b0;
        en  = 1'b1;
        jalr_en = 1'b1; jalr_target = 8'h40;  // must be ignored in BOOT
        tick();
        jalr_en = 1'b0;
        checks++; if (PC !== 8'h00) begin errors++; $display("FAIL boot_pc got=%h exp=00", PC); end
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL run_fv got=%b exp=1", fetch_valid); end
        tick();
        checks++; if (PC !== 8'h04) begin errors++; $display("FAIL seq1 got=%h exp=04", PC); end
        tick();
        checks++; if (PC !== 8'h08) begin errors++; $display("FAIL seq2 got=%h exp=08", PC); end
    endtask

    task automatic test_branch();
        reset_and_boot();
        goto_pc(8'h10);
        checks++; if (PC !== 8'h10) begin errors++; $display("FAIL goto10 got=%h exp=10", PC); end
        PCsrc = 1'b1; ImmOp = 8'hF8;
        tick();
        checks++; if (PC !== 8'h08) begin errors++; $display("FAIL br_back got=%h exp=08", PC); end
        ImmOp = 8'h0C;
        tick();
        checks++; if (PC !== 8'h14) begin errors++; $display("FAIL br_fwd got=%h exp=14", PC); end
        PCsrc = 1'b0;
    endtask

    task automatic test_jalr_priority();
        reset_and_boot();
        goto_pc(8'h20);
        jalr_en = 1'b1; jalr_target = 8'h41; PCsrc = 1'b1; ImmOp = 8'h08;
        tick();
        clear_inputs(); en = 1'b1;
        checks++; if (PC !== 8'h40) begin errors++; $display("FAIL jalr_prio got=%h exp=40", PC); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL jalr_mis got=%b exp=0", misalign); end
    endtask

    task automatic test_misalign();
        reset_and_boot();
        goto_pc(8'h20);
        jalr_en = 1'b1; jalr_target = 8'h42;
        tick();
        checks++; if (PC !== 8'h20) begin errors++; $display("FAIL mis_pc got=%h exp=20", PC); end
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_flag got=%b exp=1", misalign); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL mis_fv got=%b exp=0", fetch_valid); end
        jalr_en = 1'b0; PCsrc = 1'b1; ImmOp = 8'h04; en = 1'b1;
        tick(); tick();
        checks++; if (PC !== 8'h20) begin errors++; $display("FAIL halt_pc got=%h exp=20", PC); end
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL halt_mis got=%b exp=1", misalign); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (PC !== 8'h00) begin errors++; $display("FAIL halt_rst_pc got=%h exp=00", PC); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL halt_rst_mis got=%b exp=0", misalign); end
        // Misaligned PC-relative target also halts.
        clear_inputs(); en = 1'b1;
        tick();
        goto_pc(8'h10);
        PCsrc = 1'b1; ImmOp = 8'h02;
        tick();
        checks++; if (PC !== 8'h10) begin errors++; $display("FAIL brmis_pc got=%h exp=10", PC); end
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL brmis_flag got=%b exp=1", misalign); end
        PCsrc = 1'b0;
    endtask

    task automatic test_stall_wrap();
        reset_and_boot();
        goto_pc(8'h30);
        en = 1'b0; PCsrc = 1'b1; ImmOp = 8'h10;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (PC !== 8'h30) begin errors++; $display("FAIL stall%0d got=%h exp=30", i, PC); end
        end
        en = 1'b1; PCsrc = 1'b0;
        tick();
        checks++; if (PC !== 8'h34) begin errors++; $display("FAIL unstall got=%h exp=34", PC); end
        goto_pc(8'hFC);
        checks++; if (PC_plus4 !== 8'h00) begin errors++; $display("FAIL pc4_wrap got=%h exp=00", PC_plus4); end
        tick();
        checks++; if (PC !== 8'h00) begin errors++; $display("FAIL wrap got=%h exp=00", PC); end
    endtask

`ifdef PC_GEN_FETCH_CNT_EN
    task automatic test_fetch_count();
        reset_and_boot();
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL cnt_boot got=%0d exp=0", fetch_count); end
        for (int i = 0; i < 5; i++) tick();
        en = 1'b0;
        tick(); tick();
        checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL cnt_run got=%0d exp=5", fetch_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL cnt_rst got=%0d exp=0", fetch_count); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_branch();
        test_jalr_priority();
        test_misalign();
        test_stall_wrap();
`ifdef PC_GEN_FETCH_CNT_EN
        test_fetch_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Program-counter generator for the reduced RISC-V single-cycle core. It sits directly upstream of the instruction memory: its PC output drives the memory's byte address A. It computes and registers the next fetch address each cycle from three sources: sequential PC+4, a PC-relative branch/jal target, or an absolute jalr target. It also provides stall, a post-reset boot cycle, and a sticky halt on misaligned targets.

Parameters:
ADDR_LEN, 8, PC/address width in bits; equals the instruction memory address width.
RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  step enable; 0 = stall (PC holds)
PCsrc  input  1  1 = take PC-relative target PC+ImmOp
ImmOp  input  ADDR_LEN  sign-extended branch/jal offset, truncated to ADDR_LEN
jalr_en  input  1  1 = take absolute target jalr_target
jalr_target  input  ADDR_LEN  rs1+imm from ALU
PC  output  ADDR_LEN  current fetch address (registered) to instruction memory A
PC_plus4  output  ADDR_LEN  PC+4 (combinational), for link writeback
fetch_valid  output  1  1 = the instruction at PC is to be executed this cycle
misalign  output  1  sticky misaligned-target error flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: on a rising edge with rst=1, set PC=RESET_PC, state=BOOT, misalign=0. rst has priority over every other input. Reset asserted mid-run aborts any pending redirect.
- Reset values: fetch_valid=0, misalign=0, PC=RESET_PC, PC_plus4=RESET_PC+4.
- States: BOOT, RUN, HALT. The state is internal.
- BOOT: lasts exactly one cycle after rst deasserts. fetch_valid=0. PC holds. Next state is RUN unconditionally, regardless of en.
- RUN: fetch_valid=1.
  - en=0: PC holds (stall). Redirect inputs are ignored.
  - en=1: next PC is chosen with priority jalr_en > PCsrc > sequential.
  - jalr target = jalr_target with bit0 forced to 0.
  - Branch target = PC+ImmOp.
  - Sequential target = PC+4.
- HALT: fetch_valid=0, PC frozen, misalign=1. Only rst exits HALT.
- Misalign check: applies in RUN with en=1 to the selected target (after the jalr bit0 clear). If target[1:0] != 0, the PC is NOT updated, state goes to HALT, and misalign is set on the same edge. The sequential target is always aligned because PC is aligned.
- Arithmetic: all additions are modulo 2^ADDR_LEN and wrap silently with no error. Example for ADDR_LEN=8: PC=0xFC +4 -> 0x00. ImmOp is two's-complement, so PC=0x10 with ImmOp=0xF8 gives 0x08.
- Latency: a redirect presented in cycle n appears on PC in cycle n+1. Instruction memory read data for PC is combinational, in the same cycle.
- Simultaneous jalr_en=1 and PCsrc=1: jalr wins.
- Redirect inputs in BOOT or HALT are ignored.
- Outputs are glitch-free registered except PC_plus4 and fetch_valid. fetch_valid is decoded from the state register only.

Optional Feature:
Macro: PC_GEN_FETCH_CNT_EN
- Defined:
  - Adds output fetch_count, 32 bits.
  - fetch_count resets to 0.
  - It increments on each rising edge where state=RUN and en=1, including the edge that enters HALT.
  - It saturates at 0xFFFF_FFFF.
  - It holds in BOOT, HALT and stall.
- Not defined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
1. rst=1 for 2 cycles, then release with en=1 -> cycle 0 after release: PC=0x00, fetch_valid=0 (BOOT). Next edges: PC=0x00 with fetch_valid=1, then 0x04, then 0x08.
2. In RUN at PC=0x10, PCsrc=1, ImmOp=0xF8 -> next PC=0x08. Then PCsrc=1, ImmOp=0x0C at PC=0x08 -> 0x14.
3. At PC=0x20: jalr_en=1, jalr_target=0x41, PCsrc=1, ImmOp=0x08 -> next PC=0x40 (jalr priority, bit0 cleared), misalign=0.
4. At PC=0x20: jalr_en=1, jalr_target=0x42 -> PC stays 0x20, misalign=1, fetch_valid=0. Further en/redirect inputs have no effect. Then rst=1 -> PC=0x00, misalign=0.
5. At PC=0x30: en=0 for 3 cycles with PCsrc=1 -> PC stays 0x30. Then en=1, PCsrc=0 -> 0x34. Also PC=0xFC, en=1 -> 0x00 (wrap).
6. With PC_GEN_FETCH_CNT_EN defined: run 5 enabled RUN cycles and 2 stall cycles -> fetch_count=5. Assert rst -> fetch_count=0.
